// File: rtl/phase_a_driver.sv
// -----------------------------------------------------------------------------
// phase_a_driver
//
// Streams the operands of one phase_a operation in over a valid/ready word
// interface, fires phase_a with a one-cycle start pulse, waits (with timeout)
// for phase_a to report done, captures its result and streams the result back
// out over a second valid/ready word interface.
//
// Word stream layout (LSW first, WORD_W = 64 gives 146 words):
//   words [0, A_WORDS)              -> a_o
//   words [A_WORDS, 2*A_WORDS)      -> m_o
//   words [2*A_WORDS, 3*A_WORDS)    -> m_n_o[3071:0]
//   word  3*A_WORDS                 -> m_n_o[3073:3072] from bits [1:0]
//   word  3*A_WORDS+1               -> m_prime_o from bits [55:0]
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous abort back to LOAD (operands/result kept)
//   in_valid/in_ready/in_data     operand word stream
//   a_o, m_o, m_n_o, m_prime_o    operands presented to phase_a
//   start           one-cycle enable pulse to phase_a
//   done, new_a     completion strobe and result from phase_a
//   out_valid/out_ready/out_data  result word stream
//   busy            high while an operation is in flight
//   err             sticky timeout flag, cleared by clear or rst
// -----------------------------------------------------------------------------
module phase_a_driver #(
   parameter int WORD_W  = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic [3071:0]     a_o,
   output logic [3071:0]     m_o,
   output logic [3073:0]     m_n_o,
   output logic [55:0]       m_prime_o,
   output logic              start,
   input  logic              done,
   input  logic [3071:0]     new_a,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              busy,
   output logic              err
);

   localparam int A_BITS  = 3072;
   localparam int MN_BITS = 3074;
   localparam int MP_BITS = 56;

   // Word-index map of the load stream.
   localparam int A_WORDS = A_BITS / WORD_W;
   localparam int M_BASE  = A_WORDS;
   localparam int MN_BASE = 2 * A_WORDS;
   localparam int MN_TOP  = MN_BASE + A_WORDS;   // carries m_n bits [3073:3072]
   localparam int MP_IDX  = MN_TOP + 1;          // last word of the load

   localparam int IDX_W   = $clog2(MP_IDX + 1);
   localparam int OUT_W   = $clog2(A_WORDS);
   localparam int CNT_W   = $clog2(TIMEOUT + 1);
   localparam int OFF_W   = $clog2(MN_BITS);

   typedef enum logic [2:0] {
      S_LOAD   = 3'd0,
      S_START  = 3'd1,
      S_WAIT   = 3'd2,
      S_UNLOAD = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   // Bit offset of word w inside a wide operand register.
   function automatic logic [OFF_W-1:0] word_off(input logic [IDX_W-1:0] w);
      return OFF_W'(w) * OFF_W'(WORD_W);
   endfunction

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   in_idx_q, in_idx_d;
   logic [OUT_W-1:0]   out_idx_q, out_idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic [A_BITS-1:0]  a_q, m_q, res_q;
   logic [MN_BITS-1:0] mn_q;
   logic [MP_BITS-1:0] mp_q;

   // Strobes from the FSM to the datapath registers.
   logic               ld_we;    // write in_data at in_idx_q
   logic               cap;      // capture new_a into the result register

   // --------------------------------------------------------------------------
   // Control state
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_LOAD;
         in_idx_q  <= '0;
         out_idx_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_idx_q  <= in_idx_d;
         out_idx_q <= out_idx_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_idx_d  = in_idx_q;
      out_idx_d = out_idx_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      in_ready  = 1'b0;
      start     = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      ld_we     = 1'b0;
      cap       = 1'b0;

      unique case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ld_we = 1'b1;
               if (in_idx_q == IDX_W'(MP_IDX)) begin
                  in_idx_d = '0;
                  state_d  = S_START;
               end else begin
                  in_idx_d = in_idx_q + IDX_W'(1);
               end
            end
         end

         S_START: begin
            start   = 1'b1;
            busy    = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            busy = 1'b1;
            // done is tested first so a completion on the final allowed
            // cycle still counts as a success.
            if (done) begin
               cap       = 1'b1;
               out_idx_d = '0;
               state_d   = S_UNLOAD;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_UNLOAD: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               if (out_idx_q == OUT_W'(A_WORDS - 1)) begin
                  out_idx_d = '0;
                  state_d   = S_LOAD;
               end else begin
                  out_idx_d = out_idx_q + OUT_W'(1);
               end
            end
         end

         S_ERR: begin
            // Parked until clear or rst; err_q stays set.
         end

         default: state_d = S_LOAD;
      endcase

      // Abort overrides everything decided above, including a word accept
      // or a done capture in the same cycle.
      if (clear) begin
         state_d   = S_LOAD;
         in_idx_d  = '0;
         out_idx_d = '0;
         cnt_d     = '0;
         err_d     = 1'b0;
         ld_we     = 1'b0;
         cap       = 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Operand and result registers. Only written in LOAD (operands) or on the
   // done capture (result), so they are stable for the whole operation.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         m_q   <= '0;
         mn_q  <= '0;
         mp_q  <= '0;
         res_q <= '0;
      end else begin
         if (ld_we) begin
            if (in_idx_q < IDX_W'(M_BASE)) begin
               a_q[word_off(in_idx_q) +: WORD_W] <= in_data;
            end else if (in_idx_q < IDX_W'(MN_BASE)) begin
               m_q[word_off(in_idx_q - IDX_W'(M_BASE)) +: WORD_W] <= in_data;
            end else if (in_idx_q < IDX_W'(MN_TOP)) begin
               mn_q[word_off(in_idx_q - IDX_W'(MN_BASE)) +: WORD_W] <= in_data;
            end else if (in_idx_q == IDX_W'(MN_TOP)) begin
               // Only the two top bits of m_n live in this word.
               mn_q[MN_BITS-1:A_BITS] <= in_data[MN_BITS-A_BITS-1:0];
            end else begin
               mp_q <= in_data[MP_BITS-1:0];
            end
         end
         if (cap) begin
            res_q <= new_a;
         end
      end
   end

   assign a_o       = a_q;
   assign m_o       = m_q;
   assign m_n_o     = mn_q;
   assign m_prime_o = mp_q;
   assign err       = err_q;
   assign out_data  = res_q[word_off(IDX_W'(out_idx_q)) +: WORD_W];

endmodule

// File: tb/tb_phase_a_driver.sv
// Bench for phase_a_driver: random operand streams and results checked against
// a word-array model of the load/unload layout.
module tb_phase_a_driver;
   localparam int W  = 64;
   localparam int TO = 16;
   localparam int NW = 146;

   logic clk = 0, clk_en = 0, rst = 0, clear = 0, in_valid = 0, done = 0, out_ready = 0;
   logic in_ready, start, out_valid, busy, err;
   logic [W-1:0]  in_data = '0, out_data;
   logic [3071:0] a_o, m_o, new_a = '0;
   logic [3073:0] m_n_o;
   logic [55:0]   m_prime_o;

   int n_checks = 0, n_pass = 0;
   int start_total = 0;

   logic [63:0]   wq [NW];
   logic [3071:0] exp_a, exp_m, rr;
   logic [3073:0] exp_mn;
   logic [55:0]   exp_mp;

   phase_a_driver #(.WORD_W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .a_o(a_o), .m_o(m_o), .m_n_o(m_n_o), .m_prime_o(m_prime_o),
      .start(start), .done(done), .new_a(new_a),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .err(err)
   );

   initial forever begin
      #5;
      if (clk_en) clk = ~clk;
   end

   always @(posedge clk) if (start === 1'b1) start_total++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random;
      for (int i = 0; i < NW; i++) wq[i] = {$urandom, $urandom};
   endtask

   task automatic rand_wide(output logic [3071:0] v);
      for (int j = 0; j < 96; j++) v[j*32 +: 32] = $urandom;
   endtask

   // Expected operand registers straight from the word layout.
   task automatic build_model;
      for (int i = 0; i < 48; i++) begin
         exp_a[i*64 +: 64]  = wq[i];
         exp_m[i*64 +: 64]  = wq[48 + i];
         exp_mn[i*64 +: 64] = wq[96 + i];
      end
      exp_mn[3073:3072] = wq[144][1:0];
      exp_mp = wq[145][55:0];
   endtask

   // Streams all of wq in with random idle gaps; returns in the START cycle.
   task automatic load_all;
      int i = 0, guard = 0;
      bit acc;
      while (i < NW && guard < 2000) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
         end else begin
            in_valid = 1'b1;
            in_data  = wq[i];
         end
         acc = in_valid && in_ready;
         step;
         if (acc) i++;
         guard++;
      end
      in_valid = 1'b0;
      if (i < NW) begin
         n_checks++;
         $display("FAIL load_all timeout: accepted %0d words, required %0d", i, NW);
      end
   endtask

   task automatic test_reset;
      rst = 0;
      #1 rst = 1;
      #2;
      n_checks++; if ({start, out_valid, err, busy} !== 4'b0) $display("FAIL reset ctrl got %b exp 0000", {start, out_valid, err, busy}); else n_pass++;
      n_checks++; if (a_o !== '0 || m_o !== '0) $display("FAIL reset a/m lo got %h %h exp 0", a_o[63:0], m_o[63:0]); else n_pass++;
      n_checks++; if (m_n_o !== '0 || m_prime_o !== '0) $display("FAIL reset mn/mp got %h %h exp 0", m_n_o[63:0], m_prime_o); else n_pass++;
      n_checks++; if (out_data !== '0) $display("FAIL reset out_data got %h exp 0", out_data); else n_pass++;
      #2 rst = 0;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b exp 1", in_ready); else n_pass++;
      clk_en = 1;
      step;
   endtask

   task automatic test_full_load;
      int base;
      for (int i = 0; i < NW - 1; i++) wq[i] = 64'(i);
      wq[145] = 64'h0030332D32D384E8;
      build_model;
      base = start_total;
      load_all;
      n_checks++; if (start !== 1'b1) $display("FAIL full_load start got %b exp 1", start); else n_pass++;
      n_checks++; if (start_total - base !== 0) $display("FAIL full_load early start got %0d exp 0", start_total - base); else n_pass++;
      n_checks++; if (a_o[63:0] !== 64'd0) $display("FAIL full_load a_lsw got %h exp 0", a_o[63:0]); else n_pass++;
      n_checks++; if (a_o[3071:3008] !== 64'd47) $display("FAIL full_load a_msw got %h exp 2f", a_o[3071:3008]); else n_pass++;
      n_checks++; if (m_n_o[3073:3072] !== 2'b00) $display("FAIL full_load mn_top got %b exp 00", m_n_o[3073:3072]); else n_pass++;
      n_checks++; if (m_prime_o !== 56'h30332D32D384E8) $display("FAIL full_load m_prime got %h exp 30332d32d384e8", m_prime_o); else n_pass++;
      n_checks++; if (a_o !== exp_a || m_o !== exp_m) $display("FAIL full_load a/m lo got %h %h exp %h %h", a_o[63:0], m_o[63:0], exp_a[63:0], exp_m[63:0]); else n_pass++;
      n_checks++; if (m_n_o !== exp_mn) $display("FAIL full_load mn lo got %h exp %h", m_n_o[63:0], exp_mn[63:0]); else n_pass++;
      n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL full_load rdy/busy got %b%b exp 01", in_ready, busy); else n_pass++;
   endtask

   // Continues from the START cycle left by test_full_load.
   task automatic test_result_path;
      int k = 0, guard = 0;
      step;
      n_checks++; if (start !== 1'b0) $display("FAIL result start width got %b exp 0", start); else n_pass++;
      repeat (4) step;
      for (int j = 0; j < 48; j++) new_a[j*64 +: 64] = 64'h1000 + 64'(j);
      done = 1'b1;
      step;
      done = 1'b0;
      new_a = {96{32'hDEADBEEF}};
      while (k < 48 && guard < 1000) begin
         out_ready = 1'($urandom_range(0, 1));
         n_checks++; if (out_valid !== 1'b1) $display("FAIL result out_valid beat %0d got %b exp 1", k, out_valid); else n_pass++;
         n_checks++; if (out_data !== 64'h1000 + 64'(k)) $display("FAIL result out_data beat %0d got %h exp %h", k, out_data, 64'h1000 + 64'(k)); else n_pass++;
         if (out_ready) k++;
         step;
         guard++;
      end
      out_ready = 1'b0;
      if (k < 48) begin n_checks++; $display("FAIL result timeout beats got %0d exp 48", k); end
      n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL result end busy/valid got %b%b exp 00", busy, out_valid); else n_pass++;
      out_ready = 1'b1;
      repeat (3) begin
         step;
         n_checks++; if (out_valid !== 1'b0) $display("FAIL result extra beat got %b exp 0", out_valid); else n_pass++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_timeout;
      fill_random; build_model;
      load_all;
      n_checks++; if (start !== 1'b1) $display("FAIL timeout start got %b exp 1", start); else n_pass++;
      for (int s = 0; s < TO; s++) begin
         step;
         n_checks++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL timeout wait cycle %0d err/busy got %b%b exp 01", s, err, busy); else n_pass++;
      end
      step;
      n_checks++; if (err !== 1'b1) $display("FAIL timeout err at cycle 16 got %b exp 1", err); else n_pass++;
      n_checks++; if ({busy, out_valid, in_ready} !== 3'b000) $display("FAIL timeout err state got %b exp 000", {busy, out_valid, in_ready}); else n_pass++;
      rand_wide(rr); new_a = rr; done = 1'b1;
      step;
      done = 1'b0;
      step;
      n_checks++; if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL timeout late done got err=%b ov=%b busy=%b exp 1 0 0", err, out_valid, busy); else n_pass++;
      clear = 1'b1;
      step;
      clear = 1'b0;
      n_checks++; if (err !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL timeout clear got err=%b rdy=%b busy=%b exp 0 1 0", err, in_ready, busy); else n_pass++;
      n_checks++; if (a_o !== exp_a || m_n_o !== exp_mn || m_prime_o !== exp_mp) $display("FAIL timeout operands kept got %h exp %h", a_o[63:0], exp_a[63:0]); else n_pass++;
   endtask

   task automatic test_done_last;
      fill_random; build_model;
      load_all;
      repeat (TO) step;
      n_checks++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL done_last pre err/busy got %b%b exp 01", err, busy); else n_pass++;
      rand_wide(rr); new_a = rr; done = 1'b1;
      step;
      done = 1'b0; new_a = ~rr;
      n_checks++; if (err !== 1'b0 || out_valid !== 1'b1) $display("FAIL done_last err/valid got %b%b exp 01", err, out_valid); else n_pass++;
      out_ready = 1'b1;
      for (int k = 0; k < 48; k++) begin
         n_checks++; if (out_data !== rr[k*64 +: 64]) $display("FAIL done_last out_data beat %0d got %h exp %h", k, out_data, rr[k*64 +: 64]); else n_pass++;
         step;
      end
      out_ready = 1'b0;
      n_checks++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL done_last end busy/err got %b%b exp 00", busy, err); else n_pass++;
   endtask

   task automatic test_clear_mid_load;
      int base;
      base = start_total;
      fill_random;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = wq[i];
         step;
      end
      in_data = {$urandom, $urandom}; clear = 1'b1;
      step;
      clear = 1'b0; in_valid = 1'b0;
      fill_random; build_model;
      load_all;
      n_checks++; if (start !== 1'b1) $display("FAIL clear_load start got %b exp 1", start); else n_pass++;
      n_checks++; if (a_o !== exp_a || m_o !== exp_m) $display("FAIL clear_load a/m lo got %h %h exp %h %h", a_o[63:0], m_o[63:0], exp_a[63:0], exp_m[63:0]); else n_pass++;
      n_checks++; if (m_n_o !== exp_mn || m_prime_o !== exp_mp) $display("FAIL clear_load mn/mp got %h %h exp %h %h", m_n_o[63:0], m_prime_o, exp_mn[63:0], exp_mp); else n_pass++;
      step;
      n_checks++; if (start_total - base !== 1) $display("FAIL clear_load start pulses got %0d exp 1", start_total - base); else n_pass++;
      clear = 1'b1;
      step;
      clear = 1'b0;
      n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL clear_load abort rdy/busy got %b%b exp 10", in_ready, busy); else n_pass++;
   endtask

   task automatic test_full_op;
      int base, k = 0, guard = 0;
      fill_random; build_model;
      base = start_total;
      load_all;
      n_checks++; if (start !== 1'b1) $display("FAIL full_op start got %b exp 1", start); else n_pass++;
      n_checks++; if (a_o !== exp_a || m_o !== exp_m || m_n_o !== exp_mn || m_prime_o !== exp_mp) $display("FAIL full_op operands a lo got %h exp %h", a_o[63:0], exp_a[63:0]); else n_pass++;
      repeat ($urandom_range(1, 12)) step;
      rand_wide(rr); new_a = rr; done = 1'b1;
      step;
      done = 1'b0; new_a = ~rr;
      while (k < 48 && guard < 1000) begin
         out_ready = 1'($urandom_range(0, 1));
         n_checks++; if (out_valid !== 1'b1 || out_data !== rr[k*64 +: 64]) $display("FAIL full_op beat %0d got v=%b %h exp v=1 %h", k, out_valid, out_data, rr[k*64 +: 64]); else n_pass++;
         if (out_ready) k++;
         step;
         guard++;
      end
      out_ready = 1'b0;
      if (k < 48) begin n_checks++; $display("FAIL full_op timeout beats got %0d exp 48", k); end
      n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL full_op end busy/rdy got %b%b exp 01", busy, in_ready); else n_pass++;
      n_checks++; if (start_total - base !== 1) $display("FAIL full_op start pulses got %0d exp 1", start_total - base); else n_pass++;
      n_checks++; if (a_o !== exp_a || m_n_o !== exp_mn) $display("FAIL full_op operands stable got %h exp %h", a_o[63:0], exp_a[63:0]); else n_pass++;
   endtask

   task automatic test_reset_mid_op(input bit in_unload);
      fill_random; build_model;
      load_all;
      repeat (3) step;
      if (in_unload) begin
         rand_wide(rr); new_a = rr; done = 1'b1;
         step;
         done = 1'b0; out_ready = 1'b1;
         repeat (5) step;
         out_ready = 1'b0;
         n_checks++; if (out_valid !== 1'b1) $display("FAIL reset_mid unload valid got %b exp 1", out_valid); else n_pass++;
      end else begin
         n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_mid wait busy/valid got %b%b exp 10", busy, out_valid); else n_pass++;
      end
      #3 rst = 1'b1;
      #1;
      n_checks++; if ({start, out_valid, err, busy, in_ready} !== 5'b00001) $display("FAIL reset_mid ctrl (unload=%0d) got %b exp 00001", in_unload, {start, out_valid, err, busy, in_ready}); else n_pass++;
      n_checks++; if (a_o !== '0 || m_o !== '0 || m_n_o !== '0 || m_prime_o !== '0) $display("FAIL reset_mid operands got %h exp 0", a_o[63:0]); else n_pass++;
      n_checks++; if (out_data !== '0) $display("FAIL reset_mid out_data got %h exp 0", out_data); else n_pass++;
      #2 rst = 1'b0;
      test_full_op;
   endtask

   initial begin
      test_reset;
      test_full_load;
      test_result_path;
      test_timeout;
      test_done_last;
      test_clear_mid_load;
      test_reset_mid_op(1'b0);
      test_reset_mid_op(1'b1);
      repeat (3) test_full_op;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
